// File: rtl/dmem_wait_responder.sv
// -----------------------------------------------------------------------------
// dmem_wait_responder
// Target end of the core's data-memory interface. It accepts one request per
// idle cycle through a req/ready handshake, waits a programmable number of
// wait states, then performs the access and reports completion as a
// one-cycle rvalid pulse with read data and an error flag.
//
// Ports
//   clk      : system clock, rising-edge active
//   reset    : asynchronous active-low reset
//   req      : request valid (held by the core until ready is seen)
//   we       : 1 = write, 0 = read
//   a        : byte address, word index is a[31:2]
//   wd       : write data
//   be       : byte enables, be[i] gates wd[8i+7:8i]
//   ready    : request can be accepted on the next rising edge
//   rvalid   : one-cycle completion pulse
//   rd       : read data, zero outside the rvalid cycle
//   err      : misaligned or out-of-range access, zero outside rvalid
//   acc_cnt  : completed transactions (wraps at 16 bits)
//
// ready comes from a register, so it reads 0 during reset and for the first
// cycle after reset release. An accept only happens while that register is 1,
// so a request presented in that first cycle is simply held until ready rises.
// -----------------------------------------------------------------------------
module dmem_wait_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   input  logic [3:0]  be,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rd,
   output logic        err,
   output logic [15:0] acc_cnt
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_a;
   logic [31:0] r_wd;
   logic [3:0]  r_be;
   logic        r_ready;
   logic        r_rvalid;
   logic        r_err;
   logic [31:0] r_rd;
   logic [15:0] r_acc_cnt;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic             w_addr_err;
   logic             w_access;
   logic             w_mem_wr;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_rdata;

   // Replace the enabled bytes of a word with the matching bytes of new data.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  ben);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (ben[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

   // The index is only meaningful when w_addr_err is 0, so the upper address
   // bits dropped here never select a word on their own.
   assign w_idx      = r_a[IDX_W+1:2];
   assign w_addr_err = (r_a[1:0] != 2'b00) || (r_a[31:2] >= 30'(DEPTH_WORDS));
   assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_mem_wr   = w_access && r_we && !w_addr_err;
   assign w_rdata    = r_mem[w_idx];

   // Handshake / wait-state FSM with the registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_we     <= 1'b0;
         r_a      <= 32'd0;
         r_wd     <= 32'd0;
         r_be     <= 4'd0;
         r_ready  <= 1'b0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rd     <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
               r_rd     <= 32'd0;
               if (req && r_ready) begin
                  r_we    <= we;
                  r_a     <= a;
                  r_wd    <= wd;
                  r_be    <= be;
                  r_cnt   <= 4'(LATENCY);
                  r_ready <= 1'b0;
                  r_state <= ST_WAIT;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  // Access edge: reads capture the array, errors and writes return 0.
                  r_rvalid <= 1'b1;
                  r_err    <= w_addr_err;
                  r_rd     <= (!w_addr_err && !r_we) ? w_rdata : 32'd0;
                  r_state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
               r_rd     <= 32'd0;
               r_ready  <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
               r_rd     <= 32'd0;
               r_ready  <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Completion counter: bumps on the edge that leaves RESP, wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc_cnt <= 16'd0;
      end else if (r_state == ST_RESP) begin
         r_acc_cnt <= r_acc_cnt + 16'd1;
      end else begin
         r_acc_cnt <= r_acc_cnt;
      end
   end

   // Byte-enabled array write; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         r_mem[w_idx] <= merge_bytes(w_rdata, r_wd, r_be);
      end
   end

   assign ready   = r_ready;
   assign rvalid  = r_rvalid;
   assign rd      = r_rd;
   assign err     = r_err;
   assign acc_cnt = r_acc_cnt;

endmodule
